// File: rtl/md_unit_ctrl_if.sv
// EX-stage multiply/divide bus: instruction handshake and operands in, HI/LO and stall status out.
interface md_unit_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, A, B, input busy, stall, hi, lo);
  modport slave  (input start, op, A, B, output busy, stall, hi, lo);
endinterface

// File: rtl/md_unit_ctrl.sv
// HI/LO owner for the MIPS core: computes MULT/MULTU/DIV/DIVU results at start and
// commits them after a fixed latency, holding busy so dependent instructions stall.
module md_unit_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic          clk,
  input logic          reset,
  md_unit_ctrl_if.slave md
);
  localparam int DATA_W     = 32;
  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // One 33x33 signed multiplier serves both flavours; sgn selects sign or zero extension.
  function automatic logic [2*DATA_W-1:0] mul_full(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic sgn);
    logic signed [DATA_W:0]     sa;
    logic signed [DATA_W:0]     sb;
    logic signed [2*DATA_W+1:0] p;
    sa = {sgn & a[DATA_W-1], a};
    sb = {sgn & b[DATA_W-1], b};
    p  = sa * sb;
    return p[2*DATA_W-1:0];
  endfunction

  // Divide on magnitudes, then restore signs; this makes 0x80000000 / -1 wrap
  // to 0x80000000 and keeps the remainder's sign equal to the dividend's.
  function automatic logic [2*DATA_W-1:0] div_full(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic sgn);
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] ma;
    logic [DATA_W-1:0] mb;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    a_neg = sgn & a[DATA_W-1];
    b_neg = sgn & b[DATA_W-1];
    ma    = a_neg ? (~a + 1'b1) : a;
    mb    = b_neg ? (~b + 1'b1) : b;
    if (mb == '0) mb = {{(DATA_W-1){1'b0}}, 1'b1};
    q     = ma / mb;
    r     = ma % mb;
    if (a_neg ^ b_neg) q = ~q + 1'b1;
    if (a_neg)         r = ~r + 1'b1;
    return {r, q};
  endfunction

  logic [0:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic                busy;
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   lo;
  logic                vld_p0;
  logic [2*DATA_W-1:0] pend_p0;
  logic [2*DATA_W-1:0] result_c;
  logic                is_mul;
  logic                is_div;
  logic                accept;

  assign is_mul = (md.op == OP_MULT) || (md.op == OP_MULTU);
  assign is_div = (md.op == OP_DIV)  || (md.op == OP_DIVU);
  assign accept = md.start && (state == IDLE);

  always_comb begin
    result_c = '0;
    case (md.op)
      OP_MULT:  result_c = mul_full(md.A, md.B, 1'b1);
      OP_MULTU: result_c = mul_full(md.A, md.B, 1'b0);
      OP_DIV:   result_c = div_full(md.A, md.B, 1'b1);
      OP_DIVU:  result_c = div_full(md.A, md.B, 1'b0);
      default:  result_c = '0;
    endcase
  end

  // Stage p0: pending {hi,lo} captured at the accepting edge, held through RUN.
  always_ff @(posedge clk) begin
    if (accept && (is_mul || is_div)) pend_p0 <= result_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      vld_p0 <= 1'b0;
    end else if (state == IDLE) begin
      if (md.start) begin
        if (is_mul) begin
          cnt    <= CNT_W'(MUL_CYCLES);
          state  <= RUN;
          busy   <= 1'b1;
          vld_p0 <= 1'b1;
        end else if (is_div) begin
          cnt    <= CNT_W'(DIV_CYCLES);
          state  <= RUN;
          busy   <= 1'b1;
          vld_p0 <= (md.B != '0);
        end else if (md.op == OP_MTHI) begin
          hi <= md.A;
        end else if (md.op == OP_MTLO) begin
          lo <= md.A;
        end
      end
    end else begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        state  <= IDLE;
        busy   <= 1'b0;
        vld_p0 <= 1'b0;
        if (vld_p0) {hi, lo} <= pend_p0;
      end
    end
  end

  assign md.busy  = busy;
  assign md.stall = md.start | busy;
  assign md.hi    = hi;
  assign md.lo    = lo;
endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: latency, HI/LO results, moves, ignored starts and async reset.
module tb_md_unit_ctrl;
  logic clk;
  logic reset;
  int   passed;
  int   total;

  md_unit_ctrl_if bus ();

  md_unit_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'b111; bus.A = 32'hDEAD_BEEF; bus.B = 32'h0BAD_F00D;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 3'b111; bus.A = '0; bus.B = '0;
    repeat (2) @(negedge clk);
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
    total++; if (bus.hi !== 32'h0) $display("FAIL reset_hi got %h want 00000000", bus.hi); else passed++;
    total++; if (bus.lo !== 32'h0) $display("FAIL reset_lo got %h want 00000000", bus.lo); else passed++;
    total++; if (bus.stall !== 1'b0) $display("FAIL reset_stall got %b want 0", bus.stall); else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    int n;
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    count_busy(n);
    total++; if (n !== 5) $display("FAIL mult_busy_cycles got %0d want 5", n); else passed++;
    total++; if (bus.hi !== 32'h0000_0000) $display("FAIL mult_hi got %h want 00000000", bus.hi); else passed++;
    total++; if (bus.lo !== 32'h0000_0001) $display("FAIL mult_lo got %h want 00000001", bus.lo); else passed++;
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    count_busy(n);
    total++; if (n !== 5) $display("FAIL multu_busy_cycles got %0d want 5", n); else passed++;
    total++; if (bus.hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi got %h want fffffffe", bus.hi); else passed++;
    total++; if (bus.lo !== 32'h0000_0001) $display("FAIL multu_lo got %h want 00000001", bus.lo); else passed++;
  endtask

  task automatic test_div();
    int n;
    issue(3'b010, 32'd7, 32'hFFFF_FFFE);
    count_busy(n);
    total++; if (n !== 10) $display("FAIL div_busy_cycles got %0d want 10", n); else passed++;
    total++; if (bus.lo !== 32'hFFFF_FFFD) $display("FAIL div_lo got %h want fffffffd", bus.lo); else passed++;
    total++; if (bus.hi !== 32'h0000_0001) $display("FAIL div_hi got %h want 00000001", bus.hi); else passed++;
    issue(3'b011, 32'd7, 32'hFFFF_FFFE);
    count_busy(n);
    total++; if (n !== 10) $display("FAIL divu_busy_cycles got %0d want 10", n); else passed++;
    total++; if (bus.lo !== 32'h0) $display("FAIL divu_lo got %h want 00000000", bus.lo); else passed++;
    total++; if (bus.hi !== 32'h7) $display("FAIL divu_hi got %h want 00000007", bus.hi); else passed++;
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    total++; if (bus.lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_lo got %h want fffffffd", bus.lo); else passed++;
    total++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL div_neg_hi got %h want ffffffff", bus.hi); else passed++;
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    total++; if (bus.lo !== 32'h8000_0000) $display("FAIL div_ovf_lo got %h want 80000000", bus.lo); else passed++;
    total++; if (bus.hi !== 32'h0) $display("FAIL div_ovf_hi got %h want 00000000", bus.hi); else passed++;
  endtask

  task automatic test_move_and_div0();
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b100; bus.A = 32'h1234_5678;
    #1;
    total++; if (bus.stall !== 1'b1) $display("FAIL mthi_stall got %b want 1", bus.stall); else passed++;
    @(negedge clk);
    bus.op = 3'b101; bus.A = 32'hCAFE_F00D;
    total++; if (bus.hi !== 32'h1234_5678) $display("FAIL mthi_hi got %h want 12345678", bus.hi); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL mthi_busy got %b want 0", bus.busy); else passed++;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'b110; bus.A = '0;
    total++; if (bus.lo !== 32'hCAFE_F00D) $display("FAIL mtlo_lo got %h want cafef00d", bus.lo); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL mtlo_busy got %b want 0", bus.busy); else passed++;
    issue(3'b010, 32'd99, 32'd0);
    count_busy(n);
    total++; if (n !== 10) $display("FAIL div0_busy_cycles got %0d want 10", n); else passed++;
    total++; if (bus.hi !== 32'h1234_5678) $display("FAIL div0_hi got %h want 12345678", bus.hi); else passed++;
    total++; if (bus.lo !== 32'hCAFE_F00D) $display("FAIL div0_lo got %h want cafef00d", bus.lo); else passed++;
  endtask

  task automatic test_start_while_busy();
    int n;
    int stall_low;
    issue(3'b000, 32'd3, 32'hFFFF_FFFC);
    n = 0;
    stall_low = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      if (bus.stall !== 1'b1) stall_low++;
      if (n == 1) begin
        bus.start = 1'b1; bus.op = 3'b010; bus.A = 32'd100; bus.B = 32'd7;
      end else begin
        bus.start = 1'b0; bus.op = 3'b111;
      end
      n++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    total++; if (n !== 5) $display("FAIL busy_ignore_cycles got %0d want 5", n); else passed++;
    total++; if (stall_low !== 0) $display("FAIL busy_stall_low got %0d want 0", stall_low); else passed++;
    total++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL busy_ignore_hi got %h want ffffffff", bus.hi); else passed++;
    total++; if (bus.lo !== 32'hFFFF_FFF4) $display("FAIL busy_ignore_lo got %h want fffffff4", bus.lo); else passed++;
    repeat (2) @(negedge clk);
    total++; if (bus.busy !== 1'b0) $display("FAIL busy_ignore_noqueue got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_async_reset();
    issue(3'b010, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    total++; if (bus.busy !== 1'b1) $display("FAIL areset_pre_busy got %b want 1", bus.busy); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0) $display("FAIL areset_busy got %b want 0", bus.busy); else passed++;
    total++; if (bus.hi !== 32'h0) $display("FAIL areset_hi got %h want 00000000", bus.hi); else passed++;
    total++; if (bus.lo !== 32'h0) $display("FAIL areset_lo got %h want 00000000", bus.lo); else passed++;
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    total++; if (bus.busy !== 1'b0) $display("FAIL areset_post_busy got %b want 0", bus.busy); else passed++;
    total++; if (bus.hi !== 32'h0) $display("FAIL areset_post_hi got %h want 00000000", bus.hi); else passed++;
    total++; if (bus.lo !== 32'h0) $display("FAIL areset_post_lo got %h want 00000000", bus.lo); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_mul();
    test_div();
    test_move_and_div0();
    test_start_while_busy();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
